// File: rtl/program_loader.sv
// Boot-time loader: owns the instruction-memory write port, assembles a byte-serial image into halfword writes, then releases the CPU.
// Latency: one memory write per halfword, at least 3 cycles each; outputs registered except byte_ready_o and the RUN fetch-address pass-through.
// Backpressure: byte_valid_i/byte_ready_o handshake; upstream may stall indefinitely. Optional checksum byte enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int MEM_HALFWORDS = 512,
    parameter int CNT_W         = 16,
    parameter int WORD          = 32,
    parameter int HALF_WORD     = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_load_i,
    input  logic                 byte_valid_i,
    input  logic [7:0]           byte_i,
    output logic                 byte_ready_o,
    input  logic [WORD-1:0]      fetch_addr_i,
    output logic                 program_mem_write_en_o,
    output logic [HALF_WORD-1:0] instruction_o,
    output logic [WORD-1:0]      instruction_addr_o,
    output logic                 cpu_reset_o,
    output logic                 load_done_o,
    output logic                 load_error_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA_LO,
        S_DATA_HI,
        S_WRITE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_RUN,
        S_ERROR
    } state_t;

    // State reached once the last halfword (or an empty count) is done.
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHECK;
`else
    localparam state_t S_TAIL = S_RUN;
`endif

    state_t                 state_q, state_n;
    logic [CNT_W-1:0]       count_q, index_q, len_in, index_inc;
    logic [HALF_WORD-1:0]   instr_q;
    logic [WORD-1:0]        waddr_q, waddr_n;
    logic                   wen_q, cpu_reset_q, done_q, err_q;
    logic                   xfer;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]             sum_q;
`endif

    always_comb begin
        byte_ready_o = 1'b0;
        case (state_q)
            S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI: byte_ready_o = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK: byte_ready_o = 1'b1;
`endif
            default: byte_ready_o = 1'b0;
        endcase
    end

    assign xfer      = byte_valid_i && byte_ready_o;
    assign index_inc = index_q + 1'b1;

    always_comb begin
        len_in       = count_q;
        len_in[15:8] = byte_i;
    end

    always_comb begin
        waddr_n            = '0;
        waddr_n[CNT_W:0]   = {index_q, 1'b0};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:    if (start_load_i) state_n = S_LEN_LO;
            S_LEN_LO:  if (xfer) state_n = S_LEN_HI;
            S_LEN_HI: begin
                if (xfer) begin
                    if (len_in > CNT_W'(MEM_HALFWORDS)) state_n = S_ERROR;
                    else if (len_in == '0)              state_n = S_TAIL;
                    else                                state_n = S_DATA_LO;
                end
            end
            S_DATA_LO: if (xfer) state_n = S_DATA_HI;
            S_DATA_HI: if (xfer) state_n = S_WRITE;
            S_WRITE:   state_n = (index_inc == count_q) ? S_TAIL : S_DATA_LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK:   if (xfer) state_n = (byte_i == sum_q) ? S_RUN : S_ERROR;
`endif
            S_RUN:     if (start_load_i) state_n = S_LEN_LO;
            S_ERROR:   if (start_load_i) state_n = S_LEN_LO;
            default:   state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q     <= '0;
            index_q     <= '0;
            instr_q     <= '0;
            waddr_q     <= '0;
            wen_q       <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_LEN_LO: if (xfer) count_q[7:0] <= byte_i;
                S_LEN_HI: if (xfer) begin
                    count_q <= len_in;
                    index_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_q   <= '0;
`endif
                end
                S_DATA_LO: if (xfer) begin
                    instr_q[7:0] <= byte_i;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_q        <= sum_q + byte_i;
`endif
                end
                S_DATA_HI: if (xfer) begin
                    instr_q[15:8] <= byte_i;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_q         <= sum_q + byte_i;
`endif
                end
                S_WRITE: index_q <= index_inc;
                default: ;
            endcase
            wen_q       <= (state_n == S_WRITE);
            waddr_q     <= (state_n == S_WRITE) ? waddr_n : '0;
            cpu_reset_q <= (state_n != S_RUN);
            done_q      <= (state_n == S_RUN);
            err_q       <= (state_n == S_ERROR);
        end
    end

    assign program_mem_write_en_o = wen_q;
    assign instruction_o          = instr_q;
    assign instruction_addr_o     = (state_q == S_RUN) ? fetch_addr_i : waddr_q;
    assign cpu_reset_o            = cpu_reset_q;
    assign load_done_o            = done_q;
    assign load_error_o           = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: reset, normal/empty/oversize/max-size images, stalls with ignored start pulses, and reset abort.
module tb_program_loader;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_load_i = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_ready_o;
    logic [31:0] fetch_addr_i = 32'h0;
    logic        program_mem_write_en_o;
    logic [15:0] instruction_o;
    logic [31:0] instruction_addr_o;
    logic        cpu_reset_o;
    logic        load_done_o;
    logic        load_error_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr[$];
    logic [15:0] wr_data[$];
    logic [7:0]  img[$];

    program_loader dut (
        .clk_i                  (clk_i),
        .reset_i                (reset_i),
        .start_load_i           (start_load_i),
        .byte_valid_i           (byte_valid_i),
        .byte_i                 (byte_i),
        .byte_ready_o           (byte_ready_o),
        .fetch_addr_i           (fetch_addr_i),
        .program_mem_write_en_o (program_mem_write_en_o),
        .instruction_o          (instruction_o),
        .instruction_addr_o     (instruction_addr_o),
        .cpu_reset_o            (cpu_reset_o),
        .load_done_o            (load_done_o),
        .load_error_o           (load_error_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (program_mem_write_en_o === 1'b1) begin
            wr_addr.push_back(instruction_addr_o);
            wr_data.push_back(instruction_o);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // All tasks start and end at posedge+1.
    task automatic do_start();
        start_load_i = 1'b1;
        @(posedge clk_i); #1;
        start_load_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
        bit acc;
        repeat (gap) begin
            start_load_i = pulse;
            @(posedge clk_i); #1;
        end
        start_load_i = 1'b0;
        byte_valid_i = 1'b1;
        byte_i       = b;
        acc = 1'b0;
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clk_i);
            acc = byte_ready_o;
            @(posedge clk_i); #1;
        end
        byte_valid_i = 1'b0;
        if (!acc) chk("byte_accept", 32'(acc), 32'h1);
    endtask

    task automatic send_image(input bit stall);
        foreach (img[i])
            send_byte(img[i], stall ? int'($urandom_range(0, 3)) : 0, stall);
    endtask

    task automatic load_normal();
        img = '{8'h03, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        img.push_back(8'h6A);
`endif
    endtask

    task automatic check_normal_writes(input string tag);
        chk({tag, "_nwr"}, 32'(wr_addr.size()), 32'd3);
        if (wr_addr.size() == 3) begin
            chk({tag, "_a0"}, wr_addr[0], 32'h0);
            chk({tag, "_d0"}, 32'(wr_data[0]), 32'h1234);
            chk({tag, "_a1"}, wr_addr[1], 32'h2);
            chk({tag, "_d1"}, 32'(wr_data[1]), 32'h5678);
            chk({tag, "_a2"}, wr_addr[2], 32'h4);
            chk({tag, "_d2"}, 32'(wr_data[2]), 32'h9ABC);
        end
    endtask

    initial begin
        int bad;
        logic [7:0] sum;

        // Reset held two cycles
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_cpu_reset", 32'(cpu_reset_o), 32'h1);
        chk("rst_ready", 32'(byte_ready_o), 32'h0);
        chk("rst_wen", 32'(program_mem_write_en_o), 32'h0);
        chk("rst_done", 32'(load_done_o), 32'h0);
        chk("rst_err", 32'(load_error_o), 32'h0);
        chk("rst_addr", instruction_addr_o, 32'h0);
        chk("rst_instr", 32'(instruction_o), 32'h0);
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        chk("idle_ready", 32'(byte_ready_o), 32'h0);

        // Normal three-halfword load
        wr_addr.delete(); wr_data.delete();
        do_start();
        chk("lenlo_ready", 32'(byte_ready_o), 32'h1);
        load_normal();
        send_image(1'b0);
        @(posedge clk_i); #1;
        check_normal_writes("norm");
        chk("norm_done", 32'(load_done_o), 32'h1);
        chk("norm_cpu_reset", 32'(cpu_reset_o), 32'h0);
        chk("norm_ready", 32'(byte_ready_o), 32'h0);
        fetch_addr_i = 32'h10; #1;
        chk("fetch_10", instruction_addr_o, 32'h10);
        fetch_addr_i = 32'h1FE; #1;
        chk("fetch_1fe", instruction_addr_o, 32'h1FE);

        // Empty image, started from RUN
        wr_addr.delete(); wr_data.delete();
        do_start();
        chk("reload_cpu_reset", 32'(cpu_reset_o), 32'h1);
        chk("reload_done", 32'(load_done_o), 32'h0);
        img = '{8'h00, 8'h00};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        img.push_back(8'h00);
`endif
        send_image(1'b0);
        chk("empty_done", 32'(load_done_o), 32'h1);
        chk("empty_nwr", 32'(wr_addr.size()), 32'd0);

        // Oversize count 0x0201
        do_start();
        img = '{8'h01, 8'h02};
        send_image(1'b0);
        chk("over_err", 32'(load_error_o), 32'h1);
        chk("over_ready", 32'(byte_ready_o), 32'h0);
        chk("over_cpu_reset", 32'(cpu_reset_o), 32'h1);
        chk("over_done", 32'(load_done_o), 32'h0);
        chk("over_nwr", 32'(wr_addr.size()), 32'd0);
        do_start();
        chk("err_restart_ready", 32'(byte_ready_o), 32'h1);
        chk("err_restart_err", 32'(load_error_o), 32'h0);

        // Maximum image 0x0200 halfwords: lo = k, hi = k ^ A5
        img = '{8'h00, 8'h02};
        sum = 8'h00;
        for (int k = 0; k < 512; k++) begin
            img.push_back(8'(k));
            img.push_back(8'(k) ^ 8'hA5);
            sum = sum + 8'(k) + (8'(k) ^ 8'hA5);
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        img.push_back(sum);
`endif
        send_image(1'b0);
        @(posedge clk_i); #1;
        chk("max_nwr", 32'(wr_addr.size()), 32'd512);
        bad = 0;
        foreach (wr_addr[k])
            if (wr_addr[k] !== 32'(2 * k) || wr_data[k] !== {8'(k) ^ 8'hA5, 8'(k)}) bad++;
        chk("max_bad_writes", 32'(bad), 32'd0);
        if (wr_addr.size() == 512) begin
            chk("max_last_addr", wr_addr[511], 32'h3FE);
            chk("max_last_data", 32'(wr_data[511]), 32'h5AFF);
        end
        chk("max_done", 32'(load_done_o), 32'h1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Bad checksum byte
        wr_addr.delete(); wr_data.delete();
        do_start();
        load_normal();
        img[8] = 8'h00;
        send_image(1'b0);
        check_normal_writes("cksum");
        chk("cksum_err", 32'(load_error_o), 32'h1);
        chk("cksum_cpu_reset", 32'(cpu_reset_o), 32'h1);
`endif

        // Stalls with start pulses mid-load
        wr_addr.delete(); wr_data.delete();
        do_start();
        load_normal();
        send_image(1'b1);
        @(posedge clk_i); #1;
        check_normal_writes("stall");
        chk("stall_done", 32'(load_done_o), 32'h1);

        // Reset during the second write
        wr_addr.delete(); wr_data.delete();
        do_start();
        img = '{8'h03, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
        send_image(1'b0);
        chk("abort_wen_2nd", 32'(program_mem_write_en_o), 32'h1);
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        chk("abort_ready", 32'(byte_ready_o), 32'h0);
        chk("abort_wen", 32'(program_mem_write_en_o), 32'h0);
        chk("abort_cpu_reset", 32'(cpu_reset_o), 32'h1);
        chk("abort_done", 32'(load_done_o), 32'h0);
        byte_valid_i = 1'b1;
        byte_i = 8'hBC;
        repeat (5) begin @(posedge clk_i); #1; end
        byte_valid_i = 1'b0;
        chk("abort_idle_ready", 32'(byte_ready_o), 32'h0);
        chk("abort_nwr", 32'(wr_addr.size()), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
